// File: rtl/demux_pkg.sv
// Shared parameters and types for the serial-to-parallel receive path.
package demux_pkg;
    localparam int WIDTH = 4;
    localparam int SEL_W = $clog2(WIDTH);

    localparam logic MODE_AUTO   = 1'b0;
    localparam logic MODE_DIRECT = 1'b1;

    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/demux_deser_sel_counter.sv
// Mod-WIDTH lane counter; a clear that coincides with an enable counts lane 0 as consumed.
module sel_counter
    import demux_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output sel_t cnt,
    output logic last
);
    sel_t r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= en ? sel_t'(1) : '0;
        end else if (en) begin
            r_cnt <= last ? '0 : r_cnt + sel_t'(1);
        end
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == sel_t'(WIDTH - 1));
endmodule

// File: rtl/demux_deser.sv
// Rebuilds a WIDTH-bit word from a serial mux stream (AUTO) or acts as a
// registered 1:WIDTH demux steered by an external select (DIRECT).
module demux_deser
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             y_in,
    input  logic             y_valid,
    input  logic             mode,
    input  logic [SEL_W-1:0] s,
    output logic [WIDTH-1:0] t,
    output logic [SEL_W-1:0] s_cur,
    output logic             word_valid,
    input  logic             word_ack,
    output logic             overrun
);
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_t;
    logic             r_word_valid;
    logic             r_overrun;
    logic             r_prev_mode;

    logic             w_auto;
    logic             w_mode_chg;
    logic             w_clr;
    logic             w_en;
    logic             w_last;
    logic             w_complete;
    sel_t             w_cnt;

    assign w_auto     = (mode == MODE_AUTO);
    assign w_mode_chg = (mode != r_prev_mode);
    // DIRECT keeps the counter parked at 0 so AUTO always restarts on lane 0.
    assign w_clr      = w_mode_chg | ~w_auto;
    assign w_en       = y_valid & w_auto;
    assign w_complete = w_en & w_last & ~w_mode_chg;

    sel_counter u_sel_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .en   (w_en),
        .cnt  (w_cnt),
        .last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_mode <= MODE_AUTO;
        end else begin
            r_prev_mode <= mode;
        end
    end

    // On a mode change into AUTO the incoming bit is still captured, as lane 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (w_clr) begin
            r_shadow <= '0;
            if (w_en) begin
                r_shadow[0] <= y_in;
            end
        end else if (w_en && !w_last) begin
            r_shadow[w_cnt] <= y_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_t <= '0;
        end else if (w_complete) begin
            r_t <= {y_in, r_shadow[WIDTH-2:0]};
        end else if (!w_auto && y_valid) begin
            r_t[s] <= y_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_valid <= 1'b0;
        end else if (!w_auto || w_mode_chg) begin
            r_word_valid <= 1'b0;
        end else if (w_complete) begin
            r_word_valid <= 1'b1;
        end else if (word_ack && r_word_valid) begin
            r_word_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_complete && r_word_valid && !word_ack) begin
            r_overrun <= 1'b1;
        end
    end

    assign t          = r_t;
    assign s_cur      = w_cnt;
    assign word_valid = r_word_valid;
    assign overrun    = r_overrun;
endmodule

// File: tb/tb_demux_deser.sv
// Directed bench for demux_deser: one task per scenario with hand-computed expectations.
module tb_demux_deser;
    logic       clk;
    logic       rst;
    logic       y_in;
    logic       y_valid;
    logic       mode;
    logic [1:0] s;
    logic [3:0] t;
    logic [1:0] s_cur;
    logic       word_valid;
    logic       word_ack;
    logic       overrun;

    int n_pass;
    int n_total;

    demux_deser dut (
        .clk        (clk),
        .rst        (rst),
        .y_in       (y_in),
        .y_valid    (y_valid),
        .mode       (mode),
        .s          (s),
        .t          (t),
        .s_cur      (s_cur),
        .word_valid (word_valid),
        .word_ack   (word_ack),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        y_in    = b;
        y_valid = 1'b1;
        tick();
        y_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rst     = 1'b1;
            y_in    = 1'($urandom_range(0, 1));
            y_valid = 1'($urandom_range(0, 1));
            tick();
            n_total++;
            if ({t, word_valid, s_cur, overrun} !== {4'b0000, 1'b0, 2'd0, 1'b0})
                $display("FAIL reset[%0d]: got t=%b wv=%b s_cur=%0d ovr=%b, want t=0000 wv=0 s_cur=0 ovr=0",
                         i, t, word_valid, s_cur, overrun);
            else n_pass++;
        end
        rst     = 1'b0;
        y_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        y_valid = 1'b1;
        y_in = 1'b1; tick();
        y_in = 1'b1; tick();
        y_in = 1'b0; tick();
        n_total++;
        if ({t, word_valid, s_cur} !== {4'b0000, 1'b0, 2'd3})
            $display("FAIL b2b_partial: got t=%b wv=%b s_cur=%0d, want t=0000 wv=0 s_cur=3", t, word_valid, s_cur);
        else n_pass++;
        y_in = 1'b0; tick();
        y_valid = 1'b0;
        n_total++;
        if ({t, word_valid, s_cur} !== {4'b0011, 1'b1, 2'd0})
            $display("FAIL b2b_word: got t=%b wv=%b s_cur=%0d, want t=0011 wv=1 s_cur=0", t, word_valid, s_cur);
        else n_pass++;
        word_ack = 1'b1; tick(); word_ack = 1'b0;
        n_total++;
        if ({word_valid, t} !== {1'b0, 4'b0011})
            $display("FAIL b2b_ack: got wv=%b t=%b, want wv=0 t=0011", word_valid, t);
        else n_pass++;
    endtask

    task automatic test_gaps();
        logic [3:0] bits;
        logic [1:0] gap_ok;
        bits   = 4'b1001;
        gap_ok = 2'b11;
        for (int i = 0; i < 4; i++) begin
            send_bit(bits[i]);
            if (i < 3) begin
                tick(); tick();
                if (s_cur !== 2'(i + 1)) gap_ok = 2'b00;
            end
        end
        n_total++;
        if (gap_ok !== 2'b11)
            $display("FAIL gaps_s_cur_hold: got ok=%b, want 11", gap_ok);
        else n_pass++;
        n_total++;
        if ({t, word_valid, overrun} !== {4'b1001, 1'b1, 1'b0})
            $display("FAIL gaps_word: got t=%b wv=%b ovr=%b, want t=1001 wv=1 ovr=0", t, word_valid, overrun);
        else n_pass++;
        word_ack = 1'b1; tick(); word_ack = 1'b0;
    endtask

    task automatic test_overrun();
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        n_total++;
        if ({t, word_valid} !== {4'b1101, 1'b1})
            $display("FAIL ovr_first: got t=%b wv=%b, want t=1101 wv=1", t, word_valid);
        else n_pass++;
        send_bit(1); send_bit(1); send_bit(0); send_bit(0);
        n_total++;
        if ({overrun, t, word_valid} !== {1'b1, 4'b0011, 1'b1})
            $display("FAIL ovr_second: got ovr=%b t=%b wv=%b, want ovr=1 t=0011 wv=1", overrun, t, word_valid);
        else n_pass++;
        word_ack = 1'b1; tick(); word_ack = 1'b0;
        n_total++;
        if ({overrun, word_valid} !== {1'b1, 1'b0})
            $display("FAIL ovr_sticky: got ovr=%b wv=%b, want ovr=1 wv=0", overrun, word_valid);
        else n_pass++;
    endtask

    task automatic test_ack_on_complete();
        do_reset();
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        send_bit(1); send_bit(1); send_bit(0);
        word_ack = 1'b1;
        send_bit(0);
        word_ack = 1'b0;
        n_total++;
        if ({word_valid, overrun, t} !== {1'b1, 1'b0, 4'b0011})
            $display("FAIL ack_on_complete: got wv=%b ovr=%b t=%b, want wv=1 ovr=0 t=0011", word_valid, overrun, t);
        else n_pass++;
    endtask

    task automatic test_direct();
        do_reset();
        mode = 1'b1;
        s = 2'd2;
        send_bit(1);
        n_total++;
        if ({t, word_valid} !== {4'b0100, 1'b0})
            $display("FAIL direct_s2: got t=%b wv=%b, want t=0100 wv=0", t, word_valid);
        else n_pass++;
        s = 2'd0;
        send_bit(1);
        n_total++;
        if ({t, word_valid, s_cur} !== {4'b0101, 1'b0, 2'd0})
            $display("FAIL direct_s0: got t=%b wv=%b s_cur=%0d, want t=0101 wv=0 s_cur=0", t, word_valid, s_cur);
        else n_pass++;
        s = 2'd3;
        y_in = 1'b1;
        tick();
        n_total++;
        if (t !== 4'b0101)
            $display("FAIL direct_idle: got t=%b, want 0101", t);
        else n_pass++;
        mode = 1'b0;
    endtask

    task automatic test_midword_reset();
        do_reset();
        send_bit(1); send_bit(1);
        do_reset();
        n_total++;
        if ({s_cur, word_valid} !== {2'd0, 1'b0})
            $display("FAIL midrst_cleared: got s_cur=%0d wv=%b, want s_cur=0 wv=0", s_cur, word_valid);
        else n_pass++;
        send_bit(0); send_bit(0); send_bit(1);
        n_total++;
        if (word_valid !== 1'b0)
            $display("FAIL midrst_no_spurious: got wv=%b, want 0", word_valid);
        else n_pass++;
        send_bit(0);
        n_total++;
        if ({t, word_valid} !== {4'b0100, 1'b1})
            $display("FAIL midrst_word: got t=%b wv=%b, want t=0100 wv=1", t, word_valid);
        else n_pass++;
        word_ack = 1'b1; tick(); word_ack = 1'b0;
    endtask

    task automatic test_mode_toggle();
        send_bit(1); send_bit(1);
        mode = 1'b1; tick();
        mode = 1'b0;
        n_total++;
        if ({s_cur, word_valid, t} !== {2'd0, 1'b0, 4'b0100})
            $display("FAIL toggle_discard: got s_cur=%0d wv=%b t=%b, want s_cur=0 wv=0 t=0100", s_cur, word_valid, t);
        else n_pass++;
        send_bit(1);
        n_total++;
        if ({s_cur, word_valid} !== {2'd1, 1'b0})
            $display("FAIL toggle_first_bit: got s_cur=%0d wv=%b, want s_cur=1 wv=0", s_cur, word_valid);
        else n_pass++;
        send_bit(0); send_bit(0); send_bit(0);
        n_total++;
        if ({t, word_valid, overrun} !== {4'b0001, 1'b1, 1'b0})
            $display("FAIL toggle_word: got t=%b wv=%b ovr=%b, want t=0001 wv=1 ovr=0", t, word_valid, overrun);
        else n_pass++;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst      = 1'b1;
        y_in     = 1'b0;
        y_valid  = 1'b0;
        mode     = 1'b0;
        s        = 2'd0;
        word_ack = 1'b0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_overrun();
        test_ack_on_complete();
        test_direct();
        test_midword_reset();
        test_mode_toggle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
